// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIFU memory channel.
// The request and response tuples carry the default 4-bit XIF instruction id.
package fir_xifu_pkg;

  localparam int XIFU_MEM_MAX_LATENCY = 8;
  localparam int XIFU_ID_W            = 4;

  typedef struct packed {
    logic [XIFU_ID_W-1:0] id;
    logic [31:0]          addr;
    logic                 we;
    logic [3:0]           be;
    logic [31:0]          wdata;
  } xifu_mem_req_t;

  typedef struct packed {
    logic [XIFU_ID_W-1:0] id;
    logic [31:0]          rdata;
    logic                 err;
  } xifu_mem_rsp_t;

  function automatic logic [31:0] xifu_byte_merge(input logic [31:0] old_w,
                                                  input logic [31:0] new_w,
                                                  input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_xifu_delay_line.sv
// Valid-tagged shift register of LATENCY stages that advances every cycle.
// Only the valid bits are reset; payload is qualified by valid downstream.
module fir_xifu_delay_line #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0] r_vld;
  logic [WIDTH-1:0]   r_data [LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= vld_i;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    r_data[0] <= data_i;
    for (int i = 1; i < LATENCY; i++) r_data[i] <= r_data[i-1];
  end

  assign vld_o  = r_vld[LATENCY-1];
  assign data_o = r_data[LATENCY-1];

endmodule

// File: rtl/fir_xifu_mem_responder.sv
// Core-side memory responder for the FIR XIFU: local SRAM model answering
// load/store requests with in-order mem_result beats after a fixed latency.
module fir_xifu_mem_responder
  import fir_xifu_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [ID_W-1:0] mem_id_i,
  input  logic [31:0]     mem_addr_i,
  input  logic            mem_we_i,
  input  logic [3:0]      mem_be_i,
  input  logic [31:0]     mem_wdata_i,
  input  logic            stall_i,
  output logic            mem_result_valid_o,
  output logic [ID_W-1:0] mem_result_id_o,
  output logic [31:0]     mem_result_rdata_o,
  output logic            mem_result_err_o,
  output logic            busy_o
);

  localparam int AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RSP_W = $bits(xifu_mem_rsp_t);

  logic [31:0]    r_mem [MEM_WORDS];
  logic [CW-1:0]  r_count;

  xifu_mem_req_t  w_req;
  xifu_mem_rsp_t  w_rsp;
  xifu_mem_rsp_t  w_rsp_out;
  logic           w_err;
  logic           w_accept;
  logic           w_emit;
  logic [AW-1:0]  w_idx;

  assign w_req = '{id:    XIFU_ID_W'(mem_id_i),
                   addr:  mem_addr_i,
                   we:    mem_we_i,
                   be:    mem_be_i,
                   wdata: mem_wdata_i};

  assign w_err = (w_req.addr[1:0] != 2'b00) |
                 ({2'b00, w_req.addr[31:2]} >= 32'(MEM_WORDS));
  assign w_idx = w_req.addr[AW+1:2];

  // Ready only looks at registered state and stall, never at mem_valid_i.
  assign mem_ready_o = ~stall_i & ((r_count < CW'(DEPTH)) | w_emit);
  assign w_accept    = mem_valid_i & mem_ready_o & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (w_accept & w_req.we & ~w_err) begin
      r_mem[w_idx] <= xifu_byte_merge(r_mem[w_idx], w_req.wdata, w_req.be);
    end
  end

  always_comb begin
    w_rsp       = '0;
    w_rsp.id    = w_req.id;
    w_rsp.err   = w_err;
    w_rsp.rdata = (w_req.we | w_err) ? 32'h0 : r_mem[w_idx];
  end

  fir_xifu_delay_line #(
    .WIDTH   (RSP_W),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .vld_i  (w_accept),
    .data_i (w_rsp),
    .vld_o  (w_emit),
    .data_o (w_rsp_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      case ({w_accept, w_emit})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload is masked outside the strobe so idle outputs read as zero.
  assign mem_result_valid_o = w_emit;
  assign mem_result_id_o    = w_emit ? ID_W'(w_rsp_out.id) : '0;
  assign mem_result_rdata_o = w_emit ? w_rsp_out.rdata : 32'h0;
  assign mem_result_err_o   = w_emit & w_rsp_out.err;
  assign busy_o             = (r_count != '0);

endmodule

// File: tb/tb_fir_xifu_mem_responder.sv
// Scoreboard bench: two responder instances (LATENCY=2/DEPTH=4 and
// LATENCY=3/DEPTH=1) with expected results queued at accept time.
module tb_fir_xifu_mem_responder;

  localparam int LAT_A = 2;
  localparam int DEP_A = 4;
  localparam int LAT_B = 3;
  localparam int DEP_B = 1;
  localparam int MW    = 64;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_we, a_stall, a_rv, a_rerr, a_busy;
  logic [3:0]  a_id, a_be, a_rid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_stall, b_rv, b_rerr, b_busy;
  logic [3:0]  b_id, b_be, b_rid;
  logic [31:0] b_addr, b_wdata, b_rdata;

  fir_xifu_mem_responder #(.ID_W(4), .MEM_WORDS(MW), .LATENCY(LAT_A), .DEPTH(DEP_A)) u_a (
    .clk_i(clk), .rst_i(rst), .mem_valid_i(a_valid), .mem_ready_o(a_ready),
    .mem_id_i(a_id), .mem_addr_i(a_addr), .mem_we_i(a_we), .mem_be_i(a_be),
    .mem_wdata_i(a_wdata), .stall_i(a_stall), .mem_result_valid_o(a_rv),
    .mem_result_id_o(a_rid), .mem_result_rdata_o(a_rdata),
    .mem_result_err_o(a_rerr), .busy_o(a_busy));

  fir_xifu_mem_responder #(.ID_W(4), .MEM_WORDS(MW), .LATENCY(LAT_B), .DEPTH(DEP_B)) u_b (
    .clk_i(clk), .rst_i(rst), .mem_valid_i(b_valid), .mem_ready_o(b_ready),
    .mem_id_i(b_id), .mem_addr_i(b_addr), .mem_we_i(b_we), .mem_be_i(b_be),
    .mem_wdata_i(b_wdata), .stall_i(b_stall), .mem_result_valid_o(b_rv),
    .mem_result_id_o(b_rid), .mem_result_rdata_o(b_rdata),
    .mem_result_err_o(b_rerr), .busy_o(b_busy));

  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;
  int   a_waits = 0;
  bit   mon_en = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [31:0] model [MW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic issue_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [3:0] id);
    exp_t e;
    logic err;
    int   w;
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd; a_id = id;
    w = 0;
    while (!a_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    a_waits += w;
    if (!a_ready) begin
      check("a_issue_timeout", 32'(a_ready), 32'd1);
      a_valid = 1'b0;
      return;
    end
    err     = (addr[1:0] != 2'b00) || ((addr >> 2) >= MW);
    e.id    = id;
    e.err   = err;
    e.rdata = 32'h0;
    e.cyc   = cyc + LAT_A;
    if (!err) begin
      if (we) model[addr[7:2]] = merge(model[addr[7:2]], wd, be);
      else    e.rdata = model[addr[7:2]];
    end
    q_a.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle_a();
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (mon_en && a_rv) begin
      if (q_a.size() == 0) check("a_unexpected_result", 32'(q_a.size()), 32'd1);
      else begin
        e = q_a.pop_front();
        check("a_id", 32'(a_rid), 32'(e.id));
        check("a_rdata", a_rdata, e.rdata);
        check("a_err", 32'(a_rerr), 32'(e.err));
        check("a_time", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (mon_en && b_rv) begin
      if (q_b.size() == 0) check("b_unexpected_result", 32'(q_b.size()), 32'd1);
      else begin
        e = q_b.pop_front();
        check("b_id", 32'(b_rid), 32'(e.id));
        check("b_rdata", b_rdata, e.rdata);
        check("b_err", 32'(b_rerr), 32'(e.err));
        check("b_time", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   acc_cyc[$];
    int   n, lim, w0;
    exp_t e;

    rst = 1'b1;
    a_valid = 0; a_we = 0; a_id = 0; a_addr = 0; a_be = 4'hF; a_wdata = 0; a_stall = 0;
    b_valid = 0; b_we = 0; b_id = 0; b_addr = 0; b_be = 4'hF; b_wdata = 0; b_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_rvalid", 32'(a_rv), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_rid", 32'(a_rid), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_rerr", 32'(a_rerr), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    mon_en = 1'b1;

    // Store then load same word, back to back.
    issue_a(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd3);
    issue_a(1'b0, 32'h10, 4'hF, 32'h0, 4'd4);
    issue_a(1'b1, 32'h0, 4'hF, 32'h5A5A0000, 4'd1);
    idle_a();

    // Byte-enable merge.
    issue_a(1'b1, 32'h20, 4'hF, 32'h11223344, 4'd5);
    issue_a(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 4'd6);
    issue_a(1'b0, 32'h20, 4'hF, 32'h0, 4'd7);
    idle_a();

    // Misaligned, out of range load/store, then word 0 must be intact.
    issue_a(1'b0, 32'h22, 4'hF, 32'h0, 4'd8);
    issue_a(1'b0, 32'(4 * MW), 4'hF, 32'h0, 4'd9);
    issue_a(1'b1, 32'(4 * MW), 4'hF, 32'hFFFFFFFF, 4'd10);
    issue_a(1'b0, 32'h0, 4'hF, 32'h0, 4'd11);
    idle_a();
    repeat (4) @(negedge clk);

    // Stall with two requests in flight.
    issue_a(1'b0, 32'h10, 4'hF, 32'h0, 4'd12);
    issue_a(1'b0, 32'h20, 4'hF, 32'h0, 4'd13);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_stall = 1'b1; a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h8; a_id = 4'd14;
      #1 check("stall_ready", 32'(a_ready), 32'd0);
    end
    @(negedge clk);
    a_stall = 1'b0; a_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_busy_idle", 32'(a_busy), 32'd0);

    // Reset with two requests in flight plus a request during the reset cycle.
    issue_a(1'b1, 32'h30, 4'hF, 32'h01020304, 4'd15);
    issue_a(1'b1, 32'h34, 4'hF, 32'h05060708, 4'd0);
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'hBAD0BAD0; a_id = 4'd2;
    @(posedge clk);
    q_a.delete();
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;
    check("post_rst_busy", 32'(a_busy), 32'd0);
    check("post_rst_rvalid", 32'(a_rv), 32'd0);
    check("post_rst_ready", 32'(a_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_busy_later", 32'(a_busy), 32'd0);
    issue_a(1'b0, 32'h30, 4'hF, 32'h0, 4'd3);
    idle_a();
    repeat (3) @(negedge clk);

    // Full-rate alternating store/load to distinct words.
    w0 = a_waits;
    for (int j = 0; j < 8; j++) begin
      issue_a(1'b1, 32'(32'h80 + 4 * j), 4'hF, $urandom, 4'(2 * j));
      issue_a(1'b0, 32'(32'h80 + 4 * j), 4'hF, 32'h0, 4'(2 * j + 1));
    end
    idle_a();
    check("b2b_waits", 32'(a_waits - w0), 32'd0);
    lim = 0;
    while (q_a.size() != 0 && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    check("a_drained", 32'(q_a.size()), 32'd0);
    check("a_busy_end", 32'(a_busy), 32'd0);

    // DEPTH=1, LATENCY=3 with valid held high.
    n = 0; lim = 0;
    while (n < 6 && lim < 100) begin
      @(negedge clk);
      b_valid = 1'b1; b_we = 1'b1; b_addr = 32'(4 * n); b_wdata = 32'(n); b_id = 4'(n);
      if (b_ready) begin
        e.id = 4'(n); e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc + LAT_B;
        q_b.push_back(e);
        acc_cyc.push_back(cyc);
        n++;
      end
      lim++;
    end
    @(negedge clk);
    b_valid = 1'b0;
    check("b_accepts", 32'(n), 32'd6);
    for (int i = 1; i < acc_cyc.size(); i++) check("b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    lim = 0;
    while (q_b.size() != 0 && lim < 20) begin
      @(negedge clk);
      lim++;
    end
    check("b_drained", 32'(q_b.size()), 32'd0);
    check("b_busy_end", 32'(b_busy), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_xifu_mem_responder.md
# fir_xifu_mem_responder

Core-side responder for the FIR XIFU memory channel: accepts load/store requests issued by the coprocessor's memory stage, performs them on a local word-addressed SRAM model, and returns in-order `mem_result` beats after a fixed latency. It stands in for the cv32e40x LSU path in standalone coprocessor benches and FPGA bring-up, driving exactly the `mem_result` traffic the write-back stage consumes for `INSTR_XFIRLW` and `INSTR_XFIRSW`.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- `ID_W`, default 4: width of the XIF instruction id.
- `MEM_WORDS`, default 1024: SRAM depth in 32-bit words.
- `LATENCY`, default 2: accept-to-result latency in cycles, legal range 1..8.
- `DEPTH`, default 4: maximum outstanding requests, legal range 1..8.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `mem_valid_i`  in  1  request valid.
- `mem_ready_o`  out  1  request accepted when high together with `mem_valid_i`.
- `mem_id_i`  in  ID_W  instruction id.
- `mem_addr_i`  in  32  byte address.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_be_i`  in  4  byte enables; stores only.
- `mem_wdata_i`  in  32  store data.
- `stall_i`  in  1  test backpressure; forces `mem_ready_o` low.
- `mem_result_valid_o`  out  1  single-cycle result strobe; no ready.
- `mem_result_id_o`  out  ID_W  id of the returned request.
- `mem_result_rdata_o`  out  32  load data; 0 for stores and errors.
- `mem_result_err_o`  out  1  access error.
- `busy_o`  out  1  one or more requests outstanding.

## Operation
- Accept: `mem_valid_i & mem_ready_o` sampled at a rising edge. At most one request is accepted per cycle.
- Ready: `mem_ready_o = ~stall_i & (count < DEPTH | emit)`.
  - `emit` is the registered result valid of the current cycle, so a retiring slot frees capacity in the same cycle.
  - There is no combinational path from `mem_valid_i` to `mem_ready_o`.
- Error check:
  - `err = (mem_addr_i[1:0] != 0) | (mem_addr_i[31:2] >= MEM_WORDS)`.
  - On error, a store is suppressed and a load returns rdata 0.
- Access at the accept edge:
  - A store writes the enabled bytes of word `addr[31:2]`.
  - A load reads the word as it stood before that edge's write. No same-cycle conflict is possible because only one request is accepted per cycle.
- Delay line: the {id, rdata, err} tuple enters a LATENCY-stage valid shift register. It shifts every cycle unconditionally because the result channel has no backpressure.
- Result ordering: results leave strictly in acceptance order.
- Outstanding counter `count` (0..DEPTH):
  - +1 on accept, −1 on emit, unchanged when both occur in the same cycle.
  - `busy_o = (count != 0)`.
- Ids are opaque and are never checked for uniqueness.

## Timing
- Request accepted at edge k → `mem_result_valid_o` high for exactly the one cycle following edge k+LATENCY−1.
  - LATENCY=1: the result appears in the cycle right after the accept edge.
- Throughput:
  - One request per cycle when DEPTH ≥ LATENCY.
  - Otherwise at most DEPTH requests per LATENCY cycles.
- Read-after-write: a load accepted one cycle after a store to the same word returns the stored data.
- Reset (`rst_i` high at an edge):
  - Clears the delay line, `count` and all registered outputs.
  - After reset: `mem_ready_o = ~stall_i`, while all result outputs and `busy_o` are 0.
  - In-flight results are discarded.
  - SRAM contents are not reset.
  - A request presented in the reset cycle is not accepted and has no side effect.
- `stall_i` asserted mid-stream stops new accepts only; outstanding results still return on schedule.

## Structure
- `fir_xifu_pkg` gains:
  - `xifu_mem_req_t` = {id, addr, we, be, wdata}.
  - `xifu_mem_rsp_t` = {id, rdata, err}.
  - Constant `XIFU_MEM_MAX_LATENCY` = 8.
- Sub-module `fir_xifu_delay_line`: parameterized (`WIDTH`, `LATENCY`) valid-tagged shift register with synchronous reset. The responder holds the SRAM array, the error check, the counter and the ready logic.

## Test plan
- LATENCY=2: store 0xDEADBEEF to 0x10 with be=0xF (id 3), then load 0x10 (id 4) → results id3 (rdata 0, err 0) and id4 (rdata 0xDEADBEEF) on consecutive cycles, 2 cycles after each accept.
- Byte enables: with 0x11223344 already at 0x20, store 0xAABBCCDD to 0x20 with be=0b0101, then load 0x20 → rdata 0x11BB33DD.
- Errors: load 0x22 (misaligned) and load 4·MEM_WORDS (out of range) → err=1, rdata 0. A store to an out-of-range address → err=1, and a subsequent load of word 0 is unchanged.
- DEPTH=1, LATENCY=3: hold `mem_valid_i` high for 6 requests → `mem_ready_o` high one cycle in every 3, results in order, `count` never exceeds 1.
- Stall and reset:
  - Assert `stall_i` for 4 cycles while 2 requests are in flight → both results still return on schedule and nothing is accepted during the stall.
  - Pulse `rst_i` with 2 requests in flight → no result strobes afterwards and `busy_o` = 0.
- Back-to-back at full rate (DEPTH=4, LATENCY=2): 16 alternating store/load requests to distinct words → 16 results with ids in issue order and no bubbles.
